// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART: parity modes, FSM
// state encodings, oversampling ratio and the receiver's vote tick positions.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_EARLY = 7;
    localparam int TICK_MID   = 8;
    localparam int TICK_LATE  = 9;

    typedef enum logic [1:0] {
        PARITY_NONE     = 2'b00,
        PARITY_EVEN     = 2'b01,
        PARITY_ODD      = 2'b10,
        PARITY_NONE_ALT = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;
endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: a reloadable down-counter that emits one tick every
// div clocks, restartable so a frame's bit timing starts from a known phase.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] div_eff;

    // A divisor of zero behaves as one; the divisor is held for the whole frame.
    assign div_eff = (div == '0) ? DIV_W'(1) : div;
    assign tick    = !restart && (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= DIV_W'(1);
            count <= '0;
        end else if (restart) begin
            div_q <= div_eff;
            count <= div_eff - DIV_W'(1);
        end else if (count == '0) begin
            count <= div_q - DIV_W'(1);
        end else begin
            count <= count - DIV_W'(1);
        end
    end
endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: configurable width/stop bits, run-time divisor
// and parity, 16x oversampled receiver with voting, glitch, break and overrun.
module uart_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 send_request,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_pin,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    input  logic                 rx_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);
    localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] EARLY_TICK = 4'(TICK_EARLY);
    localparam logic [3:0] MID_TICK   = 4'(TICK_MID);
    localparam logic [3:0] LATE_TICK  = 4'(TICK_LATE);
    localparam logic [2:0] LAST_DATA  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);

    parity_mode_e mode_in;
    logic         mode_par_en;
    logic         mode_par_odd;

    assign mode_in      = parity_mode_e'(parity_mode);
    assign mode_par_en  = (mode_in == PARITY_EVEN) || (mode_in == PARITY_ODD);
    assign mode_par_odd = (mode_in == PARITY_ODD);

    tx_state_e            tx_state, tx_next;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par_bit, tx_par_en;
    logic [3:0]           tx_tick_cnt;
    logic [2:0]           tx_bit_cnt;
    logic                 tx_tick, tx_accept, tx_bit_end;

    assign tx_accept  = (tx_state == TX_IDLE) && send_request;
    assign tx_bit_end = tx_tick && (tx_tick_cnt == LAST_TICK);
    assign tx_busy    = (tx_state != TX_IDLE);

    uart_baud_tick #(.DIV_W(DIV_W)) u_tx_tick (
        .clk(clk), .reset(reset), .restart(tx_accept), .div(baud_div), .tick(tx_tick)
    );

    always_comb begin
        tx_next = tx_state;
        tx_pin  = 1'b1;
        tx_done = 1'b0;
        case (tx_state)
            TX_IDLE:   if (send_request) tx_next = TX_START;
            TX_START: begin
                tx_pin = 1'b0;
                if (tx_bit_end) tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx_pin = tx_shift[0];
                if (tx_bit_end && tx_bit_cnt == LAST_DATA)
                    tx_next = tx_par_en ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx_pin = tx_par_bit;
                if (tx_bit_end) tx_next = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end && tx_bit_cnt == LAST_STOP) begin
                    tx_done = 1'b1;
                    tx_next = TX_IDLE;
                end
            end
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // Payload and parity are captured at accept so host changes mid-frame are harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift    <= '0;
            tx_par_bit  <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
        end else if (tx_accept) begin
            tx_shift    <= tx_data;
            tx_par_en   <= mode_par_en;
            tx_par_bit  <= (^tx_data) ^ mode_par_odd;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
        end else if (tx_tick) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
            if (tx_bit_end) begin
                tx_bit_cnt <= (tx_next != tx_state) ? 3'd0 : tx_bit_cnt + 3'd1;
                if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
            end
        end
    end

    logic                 rx_meta, rx_sync, rx_prev;
    rx_state_e            rx_state, rx_next;
    logic [3:0]           rx_tick_cnt;
    logic [2:0]           rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_s7, rx_s8, rx_vote;
    logic                 rx_par_en, rx_par_odd, rx_par_sample, rx_seen_one;
    logic                 rx_tick, rx_start, rx_sample, rx_bit_end, rx_complete, rx_break;

    // Start detection is edge based, so after a break the line must go high first.
    assign rx_start    = (rx_state == RX_IDLE) && rx_prev && !rx_sync;
    assign rx_sample   = rx_tick && (rx_tick_cnt == LATE_TICK);
    assign rx_bit_end  = rx_tick && (rx_tick_cnt == LAST_TICK);
    assign rx_vote     = (rx_s7 & rx_s8) | (rx_s7 & rx_sync) | (rx_s8 & rx_sync);
    assign rx_break    = !rx_seen_one && !rx_vote;

    uart_baud_tick #(.DIV_W(DIV_W)) u_rx_tick (
        .clk(clk), .reset(reset), .restart(rx_start), .div(baud_div), .tick(rx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        rx_next     = rx_state;
        rx_complete = 1'b0;
        case (rx_state)
            RX_IDLE:   if (rx_start) rx_next = RX_START;
            RX_START: begin
                if (rx_tick && rx_tick_cnt == MID_TICK && rx_sync) rx_next = RX_IDLE;
                else if (rx_bit_end)                               rx_next = RX_DATA;
            end
            RX_DATA: begin
                if (rx_bit_end && rx_bit_cnt == LAST_DATA)
                    rx_next = rx_par_en ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_bit_end) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_sample) begin
                    rx_next     = RX_IDLE;
                    rx_complete = 1'b1;
                end
            end
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_tick_cnt   <= '0;
            rx_bit_cnt    <= '0;
            rx_shift      <= '0;
            rx_s7         <= 1'b1;
            rx_s8         <= 1'b1;
            rx_par_en     <= 1'b0;
            rx_par_odd    <= 1'b0;
            rx_par_sample <= 1'b0;
            rx_seen_one   <= 1'b0;
        end else if (rx_start) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_seen_one <= 1'b0;
            rx_par_en   <= mode_par_en;
            rx_par_odd  <= mode_par_odd;
        end else if (rx_tick) begin
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
            if (rx_tick_cnt == EARLY_TICK) rx_s7 <= rx_sync;
            if (rx_tick_cnt == MID_TICK)   rx_s8 <= rx_sync;
            if (rx_sample) begin
                rx_seen_one <= rx_seen_one | rx_vote;
                if (rx_state == RX_DATA)   rx_shift      <= {rx_vote, rx_shift[DATA_BITS-1:1]};
                if (rx_state == RX_PARITY) rx_par_sample <= rx_vote;
            end
            if (rx_bit_end)
                rx_bit_cnt <= (rx_next != rx_state) ? 3'd0 : rx_bit_cnt + 3'd1;
        end
    end

    // A completing word beats a same-cycle ack and then does not count as overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data    <= '0;
            data_ready <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            break_det <= 1'b0;
            if (rx_ack) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
            end
            if (rx_complete) begin
                if (rx_break) begin
                    break_det <= 1'b1;
                end else begin
                    rx_data    <= rx_shift;
                    parity_err <= rx_par_en && (rx_par_sample != ((^rx_shift) ^ rx_par_odd));
                    frame_err  <= !rx_vote;
                    data_ready <= 1'b1;
                    if (data_ready && !rx_ack) overrun <= 1'b1;
                end
            end
        end
    end
endmodule
